// File: rtl/fsm_trace_decoder_if.sv
// fsm_trace_decoder_if: valid/ready word stream carrying recovered input bits.
interface fsm_trace_decoder_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/fsm_trace_decoder.sv
// fsm_trace_decoder: recovers the x input of the five-state FSM from its state trace,
// packs the bits MSB-first into words and flags/counts illegal transitions.
module fsm_trace_decoder #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          state_in,
    input  logic                state_vld,
    output logic                bit_out,
    output logic                bit_vld,
    output logic                err,
    output logic [CNT_W-1:0]    err_cnt,
    output logic                ovf,
    fsm_trace_decoder_if.master out_if
);
    localparam int CW = $clog2(DATA_W);

    logic [2:0]        prev_q, prev_d;
    logic              bit_out_q, bit_out_d;
    logic              bit_vld_q, bit_vld_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [DATA_W-2:0] asm_q, asm_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              ovf_q, ovf_d;
    logic              hit0, hit1, legal, last, xfer, done, load;
    logic [DATA_W-1:0] full_word;

    function automatic logic [2:0] succ(input logic [2:0] s, input logic x);
        return s == 3'd0 ? (x ? 3'd2 : 3'd1) :
               s == 3'd1 ? (x ? 3'd4 : 3'd3) :
               s == 3'd2 ? (x ? 3'd3 : 3'd0) :
               s == 3'd3 ? (x ? 3'd0 : 3'd4) :
                           (x ? 3'd2 : 3'd1);
    endfunction

    always_comb begin
        hit0        = state_in == succ(prev_q, 1'b0);
        hit1        = state_in == succ(prev_q, 1'b1);
        legal       = hit0 | hit1;
        full_word   = {asm_q, hit1};
        last        = bit_cnt_q == CW'(DATA_W - 1);
        xfer        = out_valid_q & out_if.out_ready;
        done        = state_vld & legal & last;
        // a completed word may load only into an empty or simultaneously draining holder
        load        = done & (~out_valid_q | xfer);
        prev_d      = state_vld ? (state_in <= 3'd4 ? state_in : 3'd0) : prev_q;
        bit_out_d   = state_vld & legal ? hit1 : bit_out_q;
        bit_vld_d   = state_vld & legal;
        err_d       = state_vld & ~legal;
        err_cnt_d   = err_d & ~&err_cnt_q ? err_cnt_q + 1'b1 : err_cnt_q;
        asm_d       = !state_vld ? asm_q : legal ? full_word[DATA_W-2:0] : '0;
        bit_cnt_d   = !state_vld ? bit_cnt_q : legal & ~last ? bit_cnt_q + 1'b1 : '0;
        out_data_d  = load ? full_word : out_data_q;
        out_valid_d = load | (out_valid_q & ~xfer);
        ovf_d       = ovf_q | (done & ~load);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q      <= 3'd0;
            bit_out_q   <= 1'b0;
            bit_vld_q   <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            asm_q       <= '0;
            bit_cnt_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            bit_out_q   <= bit_out_d;
            bit_vld_q   <= bit_vld_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            asm_q       <= asm_d;
            bit_cnt_q   <= bit_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bit_out          = bit_out_q;
    assign bit_vld          = bit_vld_q;
    assign err              = err_q;
    assign err_cnt          = err_cnt_q;
    assign ovf              = ovf_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
endmodule
